// File: rtl/lobster_pkg.sv
// Shared definitions for the lobster fetch path.
//   INST_BYTES         - size of one fetched instruction word in bytes
//   DEFAULT_ADDR_WIDTH - byte address width used by the core
//   RESET_PC           - first fetch address after reset
//   fetch_state_t      - fetch sequencer states
//   fetch_entry_t      - prefetch record {data, pc} at the default address width
package lobster_pkg;

    localparam int unsigned INST_BYTES         = 8;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 36;
    localparam logic [DEFAULT_ADDR_WIDTH-1:0] RESET_PC = 36'hF800;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [63:0]                   data;
        logic [DEFAULT_ADDR_WIDTH-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/lobster_sync_fifo.sv
// Small synchronous FIFO used as the prefetch queue.
// Ports:
//   clk, rst   - clock, synchronous active-low reset (clears storage too)
//   flush      - drop all entries (takes priority over push/pop)
//   push       - write push_data; caller guarantees the FIFO is not full
//   pop        - advance the head; caller guarantees the FIFO is not empty
//   head       - oldest entry, read straight from the storage flops
//   valid      - at least one entry present
//   level      - registered entry count
module lobster_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       valid,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            level <= level + LW'(push) - LW'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign valid = (level != '0);

endmodule

// File: rtl/lobster_fetch_unit.sv
// Instruction prefetch stage feeding the lobster_CPU decoder.
// Ports:
//   clk, rst          - clock, synchronous active-low reset
//   ce, addr          - SRAM read request and 8-byte aligned address
//   rdy, data_in      - SRAM accept strobe and read data (valid when ce & rdy)
//   redirect          - flush the queue and restart fetch at redirect_pc
//   redirect_pc       - new fetch PC, low three bits ignored
//   inst_valid/ready  - decoder handshake on the queue head
//   inst_data/inst_pc - head instruction word and its address
//   fifo_level        - occupied queue entries
module lobster_fetch_unit
    import lobster_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned            DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = ADDR_WIDTH'(lobster_pkg::RESET_PC)
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       ce,
    output logic [ADDR_WIDTH-1:0]      addr,
    input  logic                       rdy,
    input  logic [63:0]                data_in,
    input  logic                       redirect,
    input  logic [ADDR_WIDTH-1:0]      redirect_pc,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    output logic [63:0]                inst_data,
    output logic [ADDR_WIDTH-1:0]      inst_pc,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

    localparam int unsigned LW = $clog2(DEPTH + 1);

    // Same layout as fetch_entry_t, but sized by this instance's ADDR_WIDTH.
    typedef struct packed {
        logic [63:0]           data;
        logic [ADDR_WIDTH-1:0] pc;
    } entry_t;

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] redirect_base;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic                  push, pop, room;
    logic [LW:0]           level_next;
    logic [LW-1:0]         level;
    entry_t                push_entry, head_entry;
    logic                  unused_redirect_lsbs;

    assign redirect_base        = {redirect_pc[ADDR_WIDTH-1:3], 3'b000};
    assign unused_redirect_lsbs = ^redirect_pc[2:0];
    assign pc_inc               = fetch_pc_q + ADDR_WIDTH'(INST_BYTES);

    // Redirect wins over everything: the returned word and the decoder pop are both void.
    assign push = (state_q == REQ) && rdy && !redirect;
    assign pop  = inst_valid && inst_ready && !redirect;

    // Issue only when the word would have a slot after this cycle's push/pop.
    assign level_next = redirect ? '0 : ({1'b0, level} + (LW+1)'(push) - (LW+1)'(pop));
    assign room       = (32'(level_next) + 32'd1) <= DEPTH;

    assign push_entry = '{data: data_in, pc: addr_q};

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        unique case (state_q)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_d = redirect_base;
                    addr_d     = redirect_base;
                    state_d    = REQ;
                end else if (room) begin
                    addr_d  = fetch_pc_q;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    fetch_pc_d = redirect_base;
                    if (rdy) begin
                        addr_d = redirect_base;
                    end else begin
                        // Request is still owed a response; hold it and discard later.
                        state_d = DRAIN;
                    end
                end else if (rdy) begin
                    fetch_pc_d = pc_inc;
                    addr_d     = pc_inc;
                    if (!room) begin
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (redirect) begin
                    fetch_pc_d = redirect_base;
                    if (rdy) begin
                        addr_d  = redirect_base;
                        state_d = REQ;
                    end
                end else if (rdy) begin
                    addr_d  = fetch_pc_q;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
        end
    end

    lobster_sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head_entry),
        .valid     (inst_valid),
        .level     (level)
    );

    assign ce         = (state_q != IDLE);
    assign addr       = addr_q;
    assign inst_data  = head_entry.data;
    assign inst_pc    = head_entry.pc;
    assign fifo_level = level;

endmodule

// File: tb/tb_lobster_fetch_unit.sv
module tb_lobster_fetch_unit;

    localparam int unsigned AW    = 36;
    localparam int unsigned DEPTH = 4;
    localparam logic [AW-1:0] RPC = 36'hF800;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ce;
    logic [AW-1:0] addr;
    logic          rdy = 1'b0;
    logic [63:0]   data_in = '0;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          inst_valid;
    logic          inst_ready = 1'b0;
    logic [63:0]   inst_data;
    logic [AW-1:0] inst_pc;
    logic [2:0]    fifo_level;

    int vectors     = 0;
    int miscompares = 0;

    lobster_fetch_unit #(
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .RESET_PC   (RPC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ce          (ce),
        .addr        (addr),
        .rdy         (rdy),
        .data_in     (data_in),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_data   (inst_data),
        .inst_pc     (inst_pc),
        .fifo_level  (fifo_level)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mk_data(input logic [AW-1:0] a);
        return {~a[31:0], a[31:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // One outstanding request (m_active/m_addr), a flag saying its response is
    // owed but unwanted, the next PC to fetch, and a queue of returned words.
    typedef struct {
        logic [63:0]   d;
        logic [AW-1:0] pc;
    } ent_t;

    ent_t          mq[$];
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_addr;
    bit            m_active;
    bit            m_discard;

    task automatic model_step();
        bit acc;
        if (!rst) begin
            mq.delete();
            m_pc      = RPC;
            m_addr    = RPC;
            m_active  = 1'b0;
            m_discard = 1'b0;
            return;
        end
        acc = m_active && rdy;
        if (redirect) begin
            mq.delete();
            m_pc = {redirect_pc[AW-1:3], 3'b000};
            if (!m_active || acc) begin
                m_active  = 1'b1;
                m_addr    = m_pc;
                m_discard = 1'b0;
            end else begin
                m_discard = 1'b1;
            end
        end else begin
            if (mq.size() > 0 && inst_ready) void'(mq.pop_front());
            if (acc) begin
                if (m_discard) begin
                    m_discard = 1'b0;
                    m_addr    = m_pc;
                end else begin
                    mq.push_back(ent_t'{data_in, m_addr});
                    m_pc     = m_pc + AW'(8);
                    m_addr   = m_pc;
                    m_active = (mq.size() + 1) <= int'(DEPTH);
                end
            end else if (!m_active && (mq.size() + 1) <= int'(DEPTH)) begin
                m_active = 1'b1;
                m_addr   = m_pc;
            end
        end
    endtask

    task automatic model_check();
        chk("rnd_ce", 64'(ce), 64'(m_active));
        if (m_active) chk("rnd_addr", 64'(addr), 64'(m_addr));
        chk("rnd_inst_valid", 64'(inst_valid), 64'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("rnd_inst_pc", 64'(inst_pc), 64'(mq[0].pc));
            chk("rnd_inst_data", inst_data, mq[0].d);
        end
        chk("rnd_fifo_level", 64'(fifo_level), 64'(mq.size()));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit            rdy;
        bit            rd;
        bit            redir;
        logic [AW-1:0] rpc;
        bit            ce;
        logic [AW-1:0] addr;
        bit            v;
        logic [AW-1:0] pc;
        int            lvl;
    } vec_t;

    function automatic vec_t mkv(input bit r, input bit d, input bit x, input logic [AW-1:0] rp,
                                 input bit c, input logic [AW-1:0] a, input bit v,
                                 input logic [AW-1:0] p, input int l);
        vec_t t;
        t.rdy = r; t.rd = d; t.redir = x; t.rpc = rp;
        t.ce = c; t.addr = a; t.v = v; t.pc = p; t.lvl = l;
        return t;
    endfunction

    initial begin
        vec_t tv[$];
        logic [AW-1:0] rnd_pc;

        // Reset state
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ce", 64'(ce), 64'(0));
        chk("reset_addr", 64'(addr), 64'(RPC));
        chk("reset_inst_valid", 64'(inst_valid), 64'(0));
        chk("reset_inst_data", inst_data, 64'(0));
        chk("reset_inst_pc", 64'(inst_pc), 64'(0));
        chk("reset_fifo_level", 64'(fifo_level), 64'(0));
        rst = 1'b1;

        //              rdy   rd    redir rpc             | ce    addr            v     pc              lvl
        tv.push_back(mkv(1'b1,1'b0,1'b0,'0,              1'b1,36'hF800,        1'b0,'0,              0));
        tv.push_back(mkv(1'b1,1'b0,1'b0,'0,              1'b1,36'hF808,        1'b1,36'hF800,        1));
        tv.push_back(mkv(1'b1,1'b0,1'b0,'0,              1'b1,36'hF810,        1'b1,36'hF800,        2));
        tv.push_back(mkv(1'b1,1'b0,1'b0,'0,              1'b1,36'hF818,        1'b1,36'hF800,        3));
        tv.push_back(mkv(1'b1,1'b0,1'b0,'0,              1'b0,'0,              1'b1,36'hF800,        4));
        tv.push_back(mkv(1'b1,1'b0,1'b0,'0,              1'b0,'0,              1'b1,36'hF800,        4));
        tv.push_back(mkv(1'b1,1'b1,1'b0,'0,              1'b1,36'hF820,        1'b1,36'hF808,        3));
        tv.push_back(mkv(1'b1,1'b0,1'b0,'0,              1'b0,'0,              1'b1,36'hF808,        4));
        tv.push_back(mkv(1'b0,1'b1,1'b0,'0,              1'b1,36'hF828,        1'b1,36'hF810,        3));
        tv.push_back(mkv(1'b0,1'b1,1'b0,'0,              1'b1,36'hF828,        1'b1,36'hF818,        2));
        tv.push_back(mkv(1'b0,1'b1,1'b1,36'h1_0005,      1'b1,36'hF828,        1'b0,'0,              0));
        tv.push_back(mkv(1'b0,1'b1,1'b0,'0,              1'b1,36'hF828,        1'b0,'0,              0));
        tv.push_back(mkv(1'b1,1'b1,1'b0,'0,              1'b1,36'h1_0000,      1'b0,'0,              0));
        tv.push_back(mkv(1'b0,1'b1,1'b0,'0,              1'b1,36'h1_0000,      1'b0,'0,              0));
        tv.push_back(mkv(1'b1,1'b0,1'b0,'0,              1'b1,36'h1_0008,      1'b1,36'h1_0000,      1));
        tv.push_back(mkv(1'b1,1'b0,1'b0,'0,              1'b1,36'h1_0010,      1'b1,36'h1_0000,      2));
        tv.push_back(mkv(1'b1,1'b0,1'b0,'0,              1'b1,36'h1_0018,      1'b1,36'h1_0000,      3));
        tv.push_back(mkv(1'b1,1'b0,1'b0,'0,              1'b0,'0,              1'b1,36'h1_0000,      4));
        tv.push_back(mkv(1'b1,1'b1,1'b0,'0,              1'b1,36'h1_0020,      1'b1,36'h1_0008,      3));
        tv.push_back(mkv(1'b1,1'b1,1'b1,36'h2_0000,      1'b1,36'h2_0000,      1'b0,'0,              0));
        tv.push_back(mkv(1'b1,1'b1,1'b0,'0,              1'b1,36'h2_0008,      1'b1,36'h2_0000,      1));
        tv.push_back(mkv(1'b0,1'b1,1'b1,36'hF_FFFF_FFFF, 1'b1,36'h2_0008,      1'b0,'0,              0));
        tv.push_back(mkv(1'b1,1'b0,1'b0,'0,              1'b1,36'hF_FFFF_FFF8, 1'b0,'0,              0));
        tv.push_back(mkv(1'b1,1'b0,1'b0,'0,              1'b1,36'h0,           1'b1,36'hF_FFFF_FFF8, 1));
        tv.push_back(mkv(1'b1,1'b0,1'b0,'0,              1'b1,36'h8,           1'b1,36'hF_FFFF_FFF8, 2));

        foreach (tv[i]) begin
            rdy         = tv[i].rdy;
            inst_ready  = tv[i].rd;
            redirect    = tv[i].redir;
            redirect_pc = tv[i].rpc;
            data_in     = mk_data(addr);
            @(posedge clk);
            #1;
            chk($sformatf("tv%0d_ce", i), 64'(ce), 64'(tv[i].ce));
            if (tv[i].ce) chk($sformatf("tv%0d_addr", i), 64'(addr), 64'(tv[i].addr));
            chk($sformatf("tv%0d_inst_valid", i), 64'(inst_valid), 64'(tv[i].v));
            if (tv[i].v) begin
                chk($sformatf("tv%0d_inst_pc", i), 64'(inst_pc), 64'(tv[i].pc));
                chk($sformatf("tv%0d_inst_data", i), inst_data, mk_data(tv[i].pc));
            end
            chk($sformatf("tv%0d_fifo_level", i), 64'(fifo_level), 64'(tv[i].lvl));
        end
        redirect = 1'b0;

        // Reset while a request is outstanding; the response offered during reset must vanish.
        rdy = 1'b0; inst_ready = 1'b0;
        @(posedge clk); #1;
        chk("midreq_ce_before", 64'(ce), 64'(1));
        rst = 1'b0; rdy = 1'b1; data_in = mk_data(addr);
        @(posedge clk); #1;
        chk("midreq_ce", 64'(ce), 64'(0));
        chk("midreq_addr", 64'(addr), 64'(RPC));
        chk("midreq_inst_valid", 64'(inst_valid), 64'(0));
        chk("midreq_fifo_level", 64'(fifo_level), 64'(0));
        chk("midreq_inst_data", inst_data, 64'(0));
        chk("midreq_inst_pc", 64'(inst_pc), 64'(0));
        rst = 1'b1; rdy = 1'b0; inst_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_ce", 64'(ce), 64'(1));
        chk("release_addr", 64'(addr), 64'(RPC));
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("release_no_stale_valid", 64'(inst_valid), 64'(0));
        end
        rdy = 1'b1; inst_ready = 1'b0; data_in = mk_data(addr);
        @(posedge clk); #1;
        chk("release_first_valid", 64'(inst_valid), 64'(1));
        chk("release_first_pc", 64'(inst_pc), 64'(RPC));
        chk("release_first_data", inst_data, mk_data(RPC));

        // Randomized run against the reference model.
        rst = 1'b0; redirect = 1'b0;
        @(posedge clk);
        model_step();
        #1;
        model_check();
        for (int n = 0; n < 4000; n++) begin
            rst        = ($urandom_range(0, 299) != 0);
            rdy        = ($urandom_range(0, 3) != 0);
            inst_ready = ($urandom_range(0, 2) != 0);
            redirect   = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0)
                rnd_pc = 36'hF_FFFF_FFE0 + AW'($urandom_range(0, 31));
            else
                rnd_pc = {4'($urandom), $urandom};
            redirect_pc = rnd_pc;
            data_in     = {$urandom, $urandom};
            @(posedge clk);
            model_step();
            #1;
            model_check();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
